// File: rtl/regfile_mp_sb.sv
// ID-stage register file: NRD combinational read ports with optional write bypass,
// a HI/LO pair with a double-width write port, and a per-register pending-write scoreboard.
module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  input  logic [NRD*2-1:0]        rd_sel,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    hilo_we,
  input  logic [2*DATA_W-1:0]     hilo_wdata,
  input  logic                    sb_set,
  input  logic [ADDR_W-1:0]       sb_addr,
  input  logic                    sb_clr_all,
  output logic                    any_busy
);

  localparam int   NREG = 2 ** ADDR_W;
  localparam logic BYP  = (BYPASS != 0);

  localparam logic [1:0] SEL_GPR  = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;

  logic [DATA_W-1:0] gpr_q [NREG];
  logic [DATA_W-1:0] gpr_d [NREG];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [NREG-1:0]   sb_q, sb_d;
  logic              gpr_wr_s;
  logic              sb_set_s;

  // Register 0 is hard-wired: writes and scoreboard marks to it are dropped.
  function automatic logic addr_nonzero(input logic [ADDR_W-1:0] a);
    return (a != {ADDR_W{1'b0}});
  endfunction

  assign gpr_wr_s = we & addr_nonzero(waddr);
  assign sb_set_s = sb_set & addr_nonzero(sb_addr);

  // Next-state for GPRs, HI/LO and the scoreboard.
  always_comb begin
    gpr_d = gpr_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    sb_d  = sb_q;
    if (gpr_wr_s) begin
      gpr_d[waddr] = wdata;
    end else begin
      gpr_d[0] = {DATA_W{1'b0}};
    end
    if (hilo_we) begin
      hi_d = hilo_wdata[2*DATA_W-1:DATA_W];
      lo_d = hilo_wdata[DATA_W-1:0];
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
    // A flush wins over everything; otherwise the set is applied after the
    // write-clear so a new writer to the same register stays pending.
    if (sb_clr_all) begin
      sb_d = {NREG{1'b0}};
    end else begin
      if (gpr_wr_s) begin
        sb_d[waddr] = 1'b0;
      end else begin
        sb_d[0] = 1'b0;
      end
      if (sb_set_s) begin
        sb_d[sb_addr] = 1'b1;
      end else begin
        sb_d[0] = 1'b0;
      end
    end
    sb_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset taking priority over all updates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= {DATA_W{1'b0}};
      end
      hi_q <= {DATA_W{1'b0}};
      lo_q <= {DATA_W{1'b0}};
      sb_q <= {NREG{1'b0}};
    end else begin
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= gpr_d[i];
      end
      hi_q <= hi_d;
      lo_q <= lo_d;
      sb_q <= sb_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [1:0]        sel_s;
    logic              hit_s;
    logic [DATA_W-1:0] val_s;
    logic              busy_s;

    assign addr_s = rd_addr[k*ADDR_W +: ADDR_W];
    assign sel_s  = rd_sel[k*2 +: 2];
    assign hit_s  = BYP & we & (waddr == addr_s);

    // Read mux with bypass; busy is masked when the same-cycle write is forwarded.
    always_comb begin
      val_s  = {DATA_W{1'b0}};
      busy_s = 1'b0;
      if (!rst) begin
        val_s  = {DATA_W{1'b0}};
        busy_s = 1'b0;
      end else begin
        case (sel_s)
          SEL_GPR: begin
            if (!addr_nonzero(addr_s)) begin
              val_s = {DATA_W{1'b0}};
            end else if (hit_s) begin
              val_s = wdata;
            end else begin
              val_s = gpr_q[addr_s];
            end
            busy_s = sb_q[addr_s] & ~hit_s;
          end
          SEL_LO: begin
            if (BYP && hilo_we) begin
              val_s = hilo_wdata[DATA_W-1:0];
            end else begin
              val_s = lo_q;
            end
          end
          SEL_HI: begin
            if (BYP && hilo_we) begin
              val_s = hilo_wdata[2*DATA_W-1:DATA_W];
            end else begin
              val_s = hi_q;
            end
          end
          default: begin
            val_s = {DATA_W{1'b0}};
          end
        endcase
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = val_s;
    assign rd_busy[k]                  = busy_s;
  end

  assign any_busy = rst ? (|sb_q) : 1'b0;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: vector table on a bypassing instance, plus a
// hand sequence contrasting it with a non-bypassing instance on shared inputs.
module tb_regfile_mp_sb;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [3:0]  rd_sel;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        hilo_we;
  logic [63:0] hilo_wdata;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        sb_clr_all;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic        any_busy_b, any_busy_n;

  int tests_run;
  int tests_failed;

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .we(we), .waddr(waddr), .wdata(wdata), .hilo_we(hilo_we),
    .hilo_wdata(hilo_wdata), .sb_set(sb_set), .sb_addr(sb_addr), .sb_clr_all(sb_clr_all),
    .any_busy(any_busy_b)
  );

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data_n),
    .rd_busy(rd_busy_n), .we(we), .waddr(waddr), .wdata(wdata), .hilo_we(hilo_we),
    .hilo_wdata(hilo_wdata), .sb_set(sb_set), .sb_addr(sb_addr), .sb_clr_all(sb_clr_all),
    .any_busy(any_busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hwe;
    logic [63:0] hwd;
    logic        sset;
    logic [4:0]  saddr;
    logic        sclr;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [1:0]  s0;
    logic [1:0]  s1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic        eany;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic hw, input logic [63:0] hd, input logic ss, input logic [4:0] sa,
                     input logic sc, input logic [4:0] a0, input logic [4:0] a1,
                     input logic [1:0] s0, input logic [1:0] s1, input logic [31:0] e0,
                     input logic [31:0] e1, input logic [1:0] eb, input logic eany);
    vec_t v;
    v.rst = r; v.we = w; v.waddr = wa; v.wdata = wd; v.hwe = hw; v.hwd = hd;
    v.sset = ss; v.saddr = sa; v.sclr = sc; v.a0 = a0; v.a1 = a1; v.s0 = s0; v.s1 = s1;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.eany = eany;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0; hilo_we = 1'b0; hilo_wdata = 64'd0;
    sb_set = 1'b0; sb_addr = 5'd0; sb_clr_all = 1'b0; rd_addr = 10'd0; rd_sel = 4'b0000;
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; we = v.we; waddr = v.waddr; wdata = v.wdata; hilo_we = v.hwe;
    hilo_wdata = v.hwd; sb_set = v.sset; sb_addr = v.saddr; sb_clr_all = v.sclr;
    rd_addr = {v.a1, v.a0}; rd_sel = {v.s1, v.s0};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    idle();
    //  rst we wa     wdata          hwe hwd                   ss sa     sc a0     a1     s0     s1     e0             e1             eb     any
    add(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 64'd0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd5, 2'b00, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0);
    add(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 64'd0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd5, 2'b00, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0);
    add(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 2'b00, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0);
    add(1'b1, 1'b1, 5'd7, 32'h12345678, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 2'b00, 2'b00, 32'h12345678, 32'd0, 2'b00, 1'b0);
    add(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 2'b00, 2'b00, 32'h12345678, 32'd0, 2'b00, 1'b0);
    add(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 2'b00, 2'b00, 32'h12345678, 32'd0, 2'b00, 1'b0);
    add(1'b1, 1'b1, 5'd3, 32'h1, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 2'b00, 2'b00, 32'h1, 32'd0, 2'b00, 1'b0);
    add(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd3, 2'b00, 2'b00, 32'h12345678, 32'hA5A5A5A5, 2'b00, 1'b0);
    add(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd3, 2'b00, 2'b00, 32'h12345678, 32'hA5A5A5A5, 2'b00, 1'b0);
    add(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 64'h00000002_00000001, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b10, 2'b01, 32'd2, 32'd1, 2'b00, 1'b0);
    add(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b10, 2'b01, 32'd2, 32'd1, 2'b00, 1'b0);
    add(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9, 2'b00, 2'b11, 32'd0, 32'd0, 2'b00, 1'b0);
    add(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9, 2'b00, 2'b11, 32'd0, 32'd0, 2'b01, 1'b1);
    add(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9, 2'b00, 2'b11, 32'h99, 32'd0, 2'b00, 1'b1);
    add(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9, 2'b00, 2'b11, 32'h99, 32'd0, 2'b00, 1'b0);
    add(1'b1, 1'b1, 5'd4, 32'h44, 1'b0, 64'd0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd0, 2'b00, 2'b00, 32'h44, 32'd0, 2'b00, 1'b0);
    add(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd0, 2'b00, 2'b00, 32'h44, 32'd0, 2'b01, 1'b1);
    add(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b1, 5'd6, 1'b1, 5'd4, 5'd6, 2'b00, 2'b00, 32'h44, 32'd0, 2'b01, 1'b1);
    add(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd6, 2'b00, 2'b00, 32'h44, 32'd0, 2'b00, 1'b0);
    add(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b1, 5'd12, 1'b0, 5'd12, 5'd0, 2'b00, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0);
    add(1'b0, 1'b1, 5'd7, 32'h777, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd12, 5'd7, 2'b00, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0);
    add(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd12, 2'b00, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0);
    add(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b10, 2'b01, 32'd0, 32'd0, 2'b00, 1'b0);

    foreach (vq[i]) begin
      apply(vq[i]);
      @(negedge clk);
      chk($sformatf("v%0d_rd_data0", i), rd_data_b[31:0], vq[i].e0);
      chk($sformatf("v%0d_rd_data1", i), rd_data_b[63:32], vq[i].e1);
      chk($sformatf("v%0d_rd_busy", i), {30'd0, rd_busy_b}, {30'd0, vq[i].eb});
      chk($sformatf("v%0d_any_busy", i), {31'd0, any_busy_b}, {31'd0, vq[i].eany});
      next_cycle();
    end

    // Bypass versus stored-value read with a pending writer on r3.
    idle(); we = 1'b1; waddr = 5'd3; wdata = 32'h1;
    next_cycle();
    idle(); sb_set = 1'b1; sb_addr = 5'd3;
    next_cycle();
    idle(); we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5; rd_addr = {5'd3, 5'd0};
    @(negedge clk);
    chk("nobyp_rd_data1", rd_data_n[63:32], 32'h1);
    chk("nobyp_rd_busy1", {31'd0, rd_busy_n[1]}, 32'd1);
    chk("nobyp_any_busy", {31'd0, any_busy_n}, 32'd1);
    chk("byp_rd_data1", rd_data_b[63:32], 32'hA5A5A5A5);
    chk("byp_rd_busy1", {31'd0, rd_busy_b[1]}, 32'd0);
    next_cycle();
    idle(); rd_addr = {5'd3, 5'd0};
    @(negedge clk);
    chk("nobyp_after_rd_data1", rd_data_n[63:32], 32'hA5A5A5A5);
    chk("nobyp_after_busy1", {31'd0, rd_busy_n[1]}, 32'd0);
    chk("byp_after_any_busy", {31'd0, any_busy_b}, 32'd0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-cycle CPU register file, sitting in the ID stage of the pipelined core.
- Provides NRD combinational read ports with write-to-read bypass and a dedicated HI/LO pair with its own 2×DATA_W write port.
- Adds a per-register pending-write scoreboard, so ID can detect RAW hazards against in-flight writers and raise a stall.

Parameters:
- DATA_W, 32, width of each general register and of HI and LO.
- ADDR_W, 5, register address width; NREG = 2**ADDR_W general registers.
- NRD, 2, number of independent read ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-low reset; sampled on rising clk, 0 = reset.
- rd_addr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_sel  in  NRD*2  per-port source: 00 GPR, 01 LO, 10 HI, 11 zero.
- rd_data  out  NRD*DATA_W  read data, port k at [k*DATA_W +: DATA_W].
- rd_busy  out  NRD  1 = port k's GPR source has a pending writer.
- we  in  1  GPR write enable.
- waddr  in  ADDR_W  GPR write address.
- wdata  in  DATA_W  GPR write data.
- hilo_we  in  1  HI/LO write enable.
- hilo_wdata  in  2*DATA_W  {HI, LO}.
- sb_set  in  1  mark a register pending (instruction issued with a destination).
- sb_addr  in  ADDR_W  register to mark.
- sb_clr_all  in  1  flush: clear every pending bit.
- any_busy  out  1  OR of all scoreboard bits.

Behaviour:
- Reset (rst=0 at clk edge): all GPRs, HI, LO = 0; scoreboard = 0.
  - While rst=0, rd_data forced to 0, rd_busy = 0, any_busy = 0 (combinational override).
  - Reset asserted mid-operation takes priority over every write, set and clear in that cycle.
- Register 0: reads always return 0, never busy. Writes and sb_set to address 0 are ignored.
- GPR write: on clk edge with rst=1, we=1, waddr≠0 → reg[waddr] <= wdata. Latency 1 cycle to storage.
- HI/LO write: on clk edge with hilo_we=1 → HI <= hilo_wdata[2*DATA_W-1:DATA_W], LO <= hilo_wdata[DATA_W-1:0].
  - Independent of we; both may occur in the same cycle.
- Reads are combinational, zero latency.
  - rd_sel=00 with BYPASS=1, we=1, waddr==rd_addr, rd_addr≠0 → wdata; otherwise stored reg value.
  - rd_sel=01/10 with BYPASS=1 and hilo_we=1 → corresponding half of hilo_wdata; otherwise stored LO/HI.
  - rd_sel=11 → 0.
- Scoreboard: NREG-1 bits sb[1..NREG-1], sb[0] tied to 0. Per edge, in priority order:
  - sb_clr_all=1 → all bits 0, and sb_set is ignored that cycle.
  - Else a GPR write to r≠0 clears sb[r].
  - Else sb_set to r≠0 sets sb[r].
  - sb_set and write to the same r in the same cycle → sb[r]=1 (the new writer wins).
  - Set and clear to different registers both take effect.
- rd_busy[k] = (rd_sel_k==00) & sb[rd_addr_k] & ~(we & waddr==rd_addr_k).
  - A same-cycle write hides busy only when BYPASS=1; when BYPASS=0 the write does not hide busy.
  - sb_set is not visible on rd_busy until the next cycle.
  - HI/LO are not scoreboarded: rd_busy=0 for rd_sel≠00.
- any_busy reflects registered scoreboard state only.
- Read ports are fully independent; any number may address the same register.

Test Plan:
- Reset: drive rst=0 for 2 cycles with we=1, waddr=5, wdata=32'hDEADBEEF, sb_set=1 to r5 → after release, rd_addr0=5 reads 0, rd_busy=0, any_busy=0.
- Write/read and R0: write 32'h12345678 to r7, then 32'hFFFFFFFF to r0 → next cycle port0 r7 = 32'h12345678, port1 r0 = 0.
- Bypass: reg r3=32'h1; in the same cycle we=1, waddr=3, wdata=32'hA5A5A5A5, rd_addr1=3 → rd_data1=32'hA5A5A5A5 combinationally. Repeat with BYPASS=0 → 32'h1, and rd_busy1=1 if sb[3] is set.
- HI/LO: hilo_we=1, hilo_wdata=64'h00000002_00000001 → same-cycle rd_sel=10 reads 2, rd_sel=01 reads 1. Next cycle with hilo_we=0 the values are retained.
- Scoreboard lifecycle: sb_set r9 → next cycle rd_busy0=1 for r9, any_busy=1. Write r9 → busy=0 during the write cycle, sb[9]=0 after it.
- Simultaneous events: sb_set r4 and write r4 in the same cycle → sb[4]=1 after the edge. Then sb_clr_all=1 together with sb_set r6 → all bits 0 and any_busy=0.
